// File: rtl/stopwatch.sv
// Interval measurement timer: counts enabled cycles between start and stop,
// and hands the result to a consumer through a one-entry valid/ready register.
module stopwatch #(
    parameter int WIDTH = 8
) (
    input  logic             reset,
    input  logic             clk,
    input  logic             clkena,
    input  logic [WIDTH-1:0] ctrl_limit,
    input  logic             ctrl_start,
    input  logic             ctrl_stop,
    input  logic             ctrl_abort,
    output logic [WIDTH-1:0] stat_elapsed,
    output logic             stat_busy,
    output logic             stat_done,
    output logic             stat_lost,
    output logic [WIDTH-1:0] res_data,
    output logic             res_timeout,
    output logic             res_ovf,
    output logic             res_valid,
    input  logic             res_ready
);

    // Handshake: a result is offered while res_valid is 1 and is consumed on
    // any clock edge where res_valid and res_ready are both 1.

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               res_timeout_q, res_timeout_d;
    logic               res_ovf_q, res_ovf_d;
    logic               res_valid_q, res_valid_d;
    logic               done_q, done_d;
    logic               lost_q, lost_d;

    logic               capture;
    logic [WIDTH-1:0]   cap_data;
    logic               cap_timeout;

    // Measurement FSM: priority in RUN is abort > stop > limit > count.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        capture     = 1'b0;
        cap_data    = cnt_q;
        cap_timeout = 1'b0;
        if (clkena) begin
            case (state_q)
                IDLE: begin
                    if (ctrl_start) begin
                        state_d = RUN;
                        cnt_d   = WIDTH'(1);
                        ovf_d   = 1'b0;
                    end
                end
                RUN: begin
                    if (ctrl_abort) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (ctrl_stop) begin
                        state_d = IDLE;
                        capture = 1'b1;
                    end else if ((ctrl_limit != '0) && (cnt_q == ctrl_limit)) begin
                        state_d     = IDLE;
                        capture     = 1'b1;
                        cap_data    = ctrl_limit;
                        cap_timeout = 1'b1;
                    end else if (cnt_q == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Result register runs every cycle so the consumer is not tied to clkena.
    always_comb begin
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        res_ovf_d     = res_ovf_q;
        res_valid_d   = res_valid_q;
        done_d        = capture;
        lost_d        = capture & res_valid_q & ~res_ready;
        if (capture) begin
            res_valid_d   = 1'b1;
            res_data_d    = cap_data;
            res_timeout_d = cap_timeout;
            res_ovf_d     = ovf_q;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            res_ovf_q     <= 1'b0;
            res_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
            res_ovf_q     <= res_ovf_d;
            res_valid_q   <= res_valid_d;
            done_q        <= done_d;
            lost_q        <= lost_d;
        end
    end

    assign stat_elapsed = cnt_q;
    assign stat_busy    = (state_q == RUN);
    assign stat_done    = done_q;
    assign stat_lost    = lost_q;
    assign res_data     = res_data_q;
    assign res_timeout  = res_timeout_q;
    assign res_ovf      = res_ovf_q;
    assign res_valid    = res_valid_q;

endmodule

// File: tb/tb_stopwatch.sv
// Bench for stopwatch: an 8-bit and a 4-bit instance share one stimulus stream
// and are compared against an integer-count reference model.
module tb_stopwatch;

  localparam int W = 10;  // {data[7:0], timeout, ovf}

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clkena = 1'b0;
  logic [7:0] ctrl_limit = '0;
  logic ctrl_start = 1'b0;
  logic ctrl_stop = 1'b0;
  logic ctrl_abort = 1'b0;
  logic res_ready = 1'b0;
  logic mon_en = 1'b0;

  logic [7:0] a_elapsed, a_data;
  logic       a_busy, a_done, a_lost, a_timeout, a_ovf, a_valid;
  logic [3:0] b_elapsed, b_data;
  logic       b_busy, b_done, b_lost, b_timeout, b_ovf, b_valid;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // reference model: j counts enabled RUN cycles since the start
  int m_max[2] = '{255, 15};
  int m_j[2];
  int m_el[2];
  bit m_run[2];
  bit m_valid[2];
  bit m_done[2];
  bit m_lost[2];

  stopwatch #(.WIDTH(8)) u8 (
    .reset(reset), .clk(clk), .clkena(clkena), .ctrl_limit(ctrl_limit),
    .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .ctrl_abort(ctrl_abort),
    .stat_elapsed(a_elapsed), .stat_busy(a_busy), .stat_done(a_done),
    .stat_lost(a_lost), .res_data(a_data), .res_timeout(a_timeout),
    .res_ovf(a_ovf), .res_valid(a_valid), .res_ready(res_ready)
  );

  stopwatch #(.WIDTH(4)) u4 (
    .reset(reset), .clk(clk), .clkena(clkena), .ctrl_limit(ctrl_limit[3:0]),
    .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .ctrl_abort(ctrl_abort),
    .stat_elapsed(b_elapsed), .stat_busy(b_busy), .stat_done(b_done),
    .stat_lost(b_lost), .res_data(b_data), .res_timeout(b_timeout),
    .res_ovf(b_ovf), .res_valid(b_valid), .res_ready(res_ready)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_j[k] = 0; m_el[k] = 0; m_run[k] = 0;
      m_valid[k] = 0; m_done[k] = 0; m_lost[k] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_step(input int k, input bit st, input bit sp, input bit ab,
                            input bit en, input bit rd, input int lim);
    bit cap;
    int cd;
    bit cto;
    bit cov;
    cap = 0; cd = 0; cto = 0; cov = 0;
    if (en) begin
      if (!m_run[k]) begin
        if (st) begin
          m_run[k] = 1; m_j[k] = 1; m_el[k] = 1;
        end
      end else if (ab) begin
        m_run[k] = 0; m_el[k] = 0;
      end else if (sp) begin
        cap = 1; cd = m_el[k]; cov = (m_j[k] > m_max[k]); m_run[k] = 0;
      end else if (lim != 0 && m_el[k] == lim) begin
        cap = 1; cd = lim; cto = 1; cov = (m_j[k] > m_max[k]); m_run[k] = 0;
      end else begin
        m_j[k]++;
        m_el[k] = (m_j[k] > m_max[k]) ? m_max[k] : m_j[k];
      end
    end
    m_lost[k] = cap && m_valid[k] && !rd;
    m_done[k] = cap;
    if (cap) begin
      m_valid[k] = 1;
      if (k == 0) exp_q0.push_back({8'(cd), cto, cov});
      else        exp_q1.push_back({8'(cd), cto, cov});
    end else if (m_valid[k] && rd) begin
      m_valid[k] = 0;
    end
  endtask

  // driver tasks
  task automatic tick(input bit st, input bit sp, input bit ab, input bit en,
                      input bit rd, input int lim);
    @(negedge clk);
    ctrl_start = st; ctrl_stop = sp; ctrl_abort = ab;
    clkena = en; res_ready = rd; ctrl_limit = 8'(lim);
    for (int k = 0; k < 2; k++) model_step(k, st, sp, ab, en, rd, lim);
  endtask

  task automatic run_for(input int n, input bit rd, input int lim);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 1, rd, lim);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    ctrl_start = 0; ctrl_stop = 0; ctrl_abort = 0; clkena = 0; res_ready = 0;
    #1;
    chk("rst_outputs", 0, int'({a_elapsed, a_data, a_busy, a_done, a_lost, a_timeout, a_ovf, a_valid}), 0);
    chk("rst_outputs", 1, int'({b_elapsed, b_data, b_busy, b_done, b_lost, b_timeout, b_ovf, b_valid}), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // scoreboard monitor
  task automatic mon_check(input int k, input int el, input bit busy, input bit done,
                           input bit lost, input bit valid, input int data,
                           input bit to, input bit ov);
    logic [W-1:0] v;
    chk("elapsed", k, el, m_el[k]);
    chk("busy", k, int'(busy), int'(m_run[k]));
    chk("done", k, int'(done), int'(m_done[k]));
    chk("lost", k, int'(lost), int'(m_lost[k]));
    chk("valid", k, int'(valid), int'(m_valid[k]));
    if (done) begin
      if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL result_pop dut%0d got a result with none expected at %0t", k, $time);
      end else begin
        v = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk("res_data", k, data, int'(v[9:2]));
        chk("res_timeout", k, int'(to), int'(v[1]));
        chk("res_ovf", k, int'(ov), int'(v[0]));
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset && mon_en) begin
        mon_check(0, int'(a_elapsed), a_busy, a_done, a_lost, a_valid, int'(a_data), a_timeout, a_ovf);
        mon_check(1, int'(b_elapsed), b_busy, b_done, b_lost, b_valid, int'(b_data), b_timeout, b_ovf);
      end
    end
  end

  initial begin
    int lim;
    model_reset();
    #1 reset = 1'b1;
    #2;
    chk("rst_outputs", 0, int'({a_elapsed, a_data, a_busy, a_done, a_lost, a_timeout, a_ovf, a_valid}), 0);
    chk("rst_outputs", 1, int'({b_elapsed, b_data, b_busy, b_done, b_lost, b_timeout, b_ovf, b_valid}), 0);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    // stop on the 5th cycle after start, result held until ready
    tick(1, 0, 0, 1, 0, 0);
    run_for(4, 0, 0);
    tick(0, 1, 0, 1, 0, 0);
    run_for(3, 0, 0);
    tick(0, 0, 0, 1, 1, 0);
    run_for(2, 0, 0);

    // limit timeout, then abort beating stop in the limit cycle
    tick(1, 0, 0, 1, 1, 3);
    run_for(4, 1, 3);
    tick(1, 0, 0, 1, 1, 3);
    run_for(2, 1, 3);
    tick(0, 1, 1, 1, 1, 3);
    run_for(2, 1, 0);

    // clkena toggling, stop only honoured on enabled cycles
    tick(1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, 1, 0);
      tick(0, 0, 0, 1, 1, 0);
    end
    tick(0, 1, 0, 0, 1, 0);
    tick(0, 1, 0, 1, 1, 0);
    run_for(2, 1, 0);

    // long run saturates the 4-bit instance
    tick(1, 0, 0, 1, 1, 0);
    run_for(19, 1, 0);
    tick(0, 1, 0, 1, 1, 0);
    run_for(2, 1, 0);

    // overwrite with res_ready low, then capture coinciding with a read
    tick(1, 0, 0, 1, 0, 0);
    run_for(2, 0, 0);
    tick(0, 1, 0, 1, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    run_for(3, 0, 0);
    tick(0, 1, 0, 1, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    run_for(1, 0, 0);
    tick(0, 1, 0, 1, 1, 0);
    run_for(2, 1, 0);

    // reset mid-run with a pending result, then a normal measurement
    tick(1, 0, 0, 1, 0, 0);
    run_for(2, 0, 0);
    tick(0, 1, 0, 1, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    run_for(3, 0, 0);
    do_reset();
    tick(1, 0, 0, 1, 0, 0);
    run_for(5, 0, 0);
    tick(0, 1, 0, 1, 1, 0);
    run_for(2, 1, 0);

    // randomized traffic
    lim = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0)
        lim = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15));
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 2) == 0, lim);
    end
    run_for(3, 1, 0);
    @(negedge clk);

    chk("leftover_results", 0, exp_q0.size(), 0);
    chk("leftover_results", 1, exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
